// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM operand-alignment path.
package gemm_pkg;

    // Shift amount emitted for a zero-exponent lane (flushes the mantissa).
    localparam int unsigned ZERO_SHIFT = 9;

    // Exponent lanes per vector.
    localparam int unsigned LANES = 4;

    // Alignment sequencer phases.
    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_REPLAY  = 1'b1
    } state_t;

endpackage : gemm_pkg

// File: rtl/exp_offset.sv
// Per-lane right-shift amount for mantissa alignment against a block max.
// Ports:
//   exp_vec  : LANES packed lane exponents, lane i at [expWidth*i +: expWidth]
//   max_exp  : block maximum exponent (>= every nonzero lane)
//   offset_c : per-lane shift, ZERO_SHIFT for zero lanes, else max_exp - exp
module exp_offset
    import gemm_pkg::*;
#(
    parameter int unsigned expWidth = 4
) (
    input  logic [LANES*expWidth-1:0] exp_vec,
    input  logic [expWidth-1:0]       max_exp,
    output logic [LANES*expWidth-1:0] offset_c
);

    // Zero exponents mark zero operands; everything else aligns to the max.
    always_comb begin
        offset_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (exp_vec[i*expWidth +: expWidth] == '0) begin
                offset_c[i*expWidth +: expWidth] = expWidth'(ZERO_SHIFT);
            end else begin
                offset_c[i*expWidth +: expWidth] = max_exp - exp_vec[i*expWidth +: expWidth];
            end
        end
    end

endmodule : exp_offset

// File: rtl/exp_align_ctrl.sv
// Block-floating-point alignment sequencer: collects a tile of TILE_LEN
// exponent vectors while tracking the tile max exponent, then replays the
// tile emitting per-lane right-shift amounts.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   abort       : synchronous discard of the current tile (beats handshakes)
//   in_valid/in_ready/in_exp         : exponent vector input
//   out_valid/out_ready/out_offset   : per-lane shift output
//   out_max_exp : tile max exponent, out_last : final vector of tile
//   busy        : replaying, or a tile is partially collected
module exp_align_ctrl
    import gemm_pkg::*;
#(
    parameter int unsigned expWidth = 4,
    parameter int unsigned TILE_LEN = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      abort,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*expWidth-1:0] in_exp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*expWidth-1:0] out_offset,
    output logic [expWidth-1:0]       out_max_exp,
    output logic                      out_last,
    output logic                      busy
);

    localparam int unsigned VEC_W = LANES * expWidth;
    localparam int unsigned PTR_W = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TILE_LEN - 1);

    state_t               state_q;
    state_t               state_d;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [expWidth-1:0]  max_reg;
    logic [expWidth-1:0]  vmax;
    logic [expWidth-1:0]  lane;
    logic                 in_fire;
    logic                 out_fire;
    logic                 wr_last;
    logic                 rd_last;
    logic [VEC_W-1:0]     tile_buf [TILE_LEN];

    assign wr_last = (wr_ptr == LAST_IDX);
    assign rd_last = (rd_ptr == LAST_IDX);

    // Max over the incoming lanes; zero lanes never win since the seed is 0.
    always_comb begin
        vmax = '0;
        lane = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane = in_exp[i*expWidth +: expWidth];
            if (lane > vmax) begin
                vmax = lane;
            end
        end
    end

    // Next-state and handshake qualification; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        in_fire  = 1'b0;
        out_fire = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                in_fire = in_valid && !abort;
                if (in_fire && wr_last) begin
                    state_d = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                out_fire = out_ready && !abort;
                if (out_fire && rd_last) begin
                    state_d = ST_COLLECT;
                end
            end
        endcase
        if (abort) begin
            state_d = ST_COLLECT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers and running max; the first accept of a tile re-seeds the max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            max_reg <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_fire) begin
                wr_ptr  <= wr_last ? '0 : wr_ptr + PTR_W'(1);
                max_reg <= ((wr_ptr == '0) || (vmax > max_reg)) ? vmax : max_reg;
                if (wr_last) begin
                    rd_ptr <= '0;
                end
            end
            if (out_fire) begin
                rd_ptr <= rd_last ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // Tile storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            tile_buf[wr_ptr] <= in_exp;
        end
    end

    exp_offset #(
        .expWidth (expWidth)
    ) u_exp_offset (
        .exp_vec  (tile_buf[rd_ptr]),
        .max_exp  (max_reg),
        .offset_c (out_offset)
    );

    assign in_ready    = (state_q == ST_COLLECT);
    assign out_valid   = (state_q == ST_REPLAY);
    assign out_max_exp = max_reg;
    assign out_last    = out_valid && rd_last;
    assign busy        = (state_q == ST_REPLAY) || (wr_ptr != '0);

endmodule : exp_align_ctrl

// File: tb/tb_exp_align_ctrl.sv
// Scoreboard bench for exp_align_ctrl: the driver issues tiles, the monitor
// builds expected replay vectors from whole-tile arithmetic and checks them.
module tb_exp_align_ctrl;

    localparam int unsigned EW = 4;
    localparam int unsigned TL = 8;
    localparam int unsigned VW = 4 * EW;

    typedef struct {
        logic [VW-1:0] off;
        logic [EW-1:0] mx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_offset;
    logic [EW-1:0] out_max_exp;
    logic          out_last;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;

    logic [VW-1:0] part [$];
    exp_t          exp_q [$];

    exp_align_ctrl #(.expWidth(EW), .TILE_LEN(TL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_offset  (out_offset),
        .out_max_exp (out_max_exp),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int lane_of(input logic [VW-1:0] v, input int l);
        return int'((v >> (EW * l)) & VW'(15));
    endfunction

    // Expected replay: tile max of nonzero lanes, 9 for zero lanes, else max-exp.
    function automatic void build_tile();
        int   mx = 0;
        exp_t t;
        foreach (part[v])
            for (int l = 0; l < 4; l++)
                if (lane_of(part[v], l) > mx) mx = lane_of(part[v], l);
        foreach (part[v]) begin
            t.off = '0;
            for (int l = 0; l < 4; l++) begin
                int e = lane_of(part[v], l);
                int o = (e == 0) ? 9 : mx - e;
                t.off = t.off | (VW'(o) << (EW * l));
            end
            t.mx   = EW'(mx);
            t.last = (v == TL - 1);
            exp_q.push_back(t);
        end
        part.delete();
    endfunction

    // Monitor: sample mid-cycle, compare against the model, then apply handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            part.delete();
            exp_q.delete();
        end else begin
            check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("busy", 32'(busy), 32'((exp_q.size() != 0) || (part.size() != 0)));
            if (abort) begin
                part.delete();
                exp_q.delete();
            end else begin
                if (out_valid && exp_q.size() != 0) begin
                    check("out_offset", 32'(out_offset), 32'(exp_q[0].off));
                    check("out_max_exp", 32'(out_max_exp), 32'(exp_q[0].mx));
                    check("out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    part.push_back(in_exp);
                    if (part.size() == TL) build_tile();
                end
            end
        end
    end

    // Downstream ready: always on, or random per cycle.
    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [VW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {EW'(l3), EW'(l2), EW'(l1), EW'(l0)};
    endfunction

    function automatic logic [VW-1:0] rand_vec(input int maxv, input int zero_pct);
        logic [VW-1:0] v = '0;
        for (int l = 0; l < 4; l++)
            if (int'($urandom_range(0, 99)) >= zero_pct)
                v = v | (VW'($urandom_range(1, maxv)) << (EW * l));
        return v;
    endfunction

    task automatic send_vec(input logic [VW-1:0] v);
        bit ok = 0;
        in_valid = 1'b1;
        in_exp   = v;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("in_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_tile(input int maxv, input int zero_pct, input bit gaps);
        for (int i = 0; i < TL; i++) begin
            send_vec(rand_vec(maxv, zero_pct));
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (part.size() == 0);
        end
        if (!done) check("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check("out_valid_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_exp    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed tile: {3,5,7,2} with one {0,0,0,12} vector at index 4.
        for (int i = 0; i < TL; i++)
            send_vec((i == 4) ? pack4(0, 0, 0, 12) : pack4(3, 5, 7, 2));
        in_valid = 1'b0;
        wait_drain();

        // All-zero tile.
        for (int i = 0; i < TL; i++) send_vec('0);
        in_valid = 1'b0;
        wait_drain();

        // Random tiles with random downstream stalls and input gaps.
        rdy_mode = 1;
        for (int t = 0; t < 6; t++) send_tile(15, 20, 1'b1);
        wait_drain();

        // Abort after 5 accepts of a tile holding 15; next tile peaks at 6.
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send_vec(pack4(15, 1, 2, 3));
        in_exp   = pack4(15, 15, 15, 15);
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < TL; i++)
            send_vec((i == 2) ? pack4(1, 6, 0, 4) : rand_vec(6, 20));
        in_valid = 1'b0;
        wait_drain();

        // Abort while a replay handshake is in flight.
        send_tile(15, 10, 1'b0);
        wait_out_valid();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        send_tile(15, 10, 1'b0);
        wait_drain();

        // Asynchronous reset in the middle of a replay.
        rdy_mode = 1;
        send_tile(15, 10, 1'b0);
        wait_out_valid();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_tile(15, 15, 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_exp_align_ctrl
